bp_update_sched: RTL and testbench

BP_UPDATE_SCHED -- requirements
Module: bp_update_sched

---
 rtl/bp_update_sched.sv | 183 ++++++++++++++++++
 tb/tb_bp_update_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_sched.sv
// bp_update_sched -- branch predictor update scheduler.
//
// Collects branch resolutions from two branch-unit ports (port 0 is older),
// filters out non control-flow results, queues them in a small FIFO and
// streams them to the frontend predictors. On the first mispredict it
// raises a one-cycle redirect request and enters HOLD. In HOLD, resolutions
// are on the wrong path and are discarded until the controller flushes.
//
// Ports
//   clk_i, rst_ni           : clock (rising edge), async active-low reset
//   flush_i                 : pipeline flush; discards same-cycle resolutions,
//                             returns HOLD to RUN, keeps queued entries
//   res_valid_i[1:0]        : resolution valid per port
//   res_pc_i/res_target_i   : resolved PC / actual target per port
//   res_taken_i             : resolved direction per port
//   res_mispredict_i        : mispredict flag per port
//   res_cf_i                : control-flow type per port (NoCF = not a branch)
//   res_ready_o             : room for two resolutions this cycle
//   upd_valid_o/upd_ready_i : update stream handshake to the frontend
//   upd_pc_o, upd_target_o, upd_taken_o, upd_cf_o : head-of-queue update
//   mispredict_o            : one-cycle redirect request (registered)
//   mispredict_target_o     : redirect target (registered)
//   hold_o                  : FSM state register, 1 = HOLD, 0 = RUN
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// upd_valid_o never depends on upd_ready_i. Resolutions have no stall path:
// anything presented while res_ready_o=0 is dropped, so the producer must
// hold off on its own.

package bp_update_sched_pkg;
   // Same encoding as the core's control-flow type.
   typedef enum logic [2:0] {
      NoCF   = 3'd0,
      Branch = 3'd1,
      Jump   = 3'd2,
      JumpR  = 3'd3,
      Return = 3'd4
   } cf_t;
endpackage

module bp_update_sched
   import bp_update_sched_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned VLEN  = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic [1:0]            res_valid_i,
   input  logic [1:0][VLEN-1:0]  res_pc_i,
   input  logic [1:0][VLEN-1:0]  res_target_i,
   input  logic [1:0]            res_taken_i,
   input  logic [1:0]            res_mispredict_i,
   input  cf_t  [1:0]            res_cf_i,
   output logic                  res_ready_o,
   output logic                  upd_valid_o,
   input  logic                  upd_ready_i,
   output logic [VLEN-1:0]       upd_pc_o,
   output logic [VLEN-1:0]       upd_target_o,
   output logic                  upd_taken_o,
   output cf_t                   upd_cf_o,
   output logic                  mispredict_o,
   output logic [VLEN-1:0]       mispredict_target_o,
   output logic                  hold_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t          state_q;
   logic [PW-1:0]   wr_ptr_q;
   logic [PW-1:0]   rd_ptr_q;
   logic [CW-1:0]   count_q;

   logic [VLEN-1:0] pc_mem     [DEPTH];
   logic [VLEN-1:0] target_mem [DEPTH];
   logic            taken_mem  [DEPTH];
   cf_t             cf_mem     [DEPTH];

   logic            accept;
   logic            need0;
   logic            need1;
   logic            push0;
   logic            push1;
   logic            pop;
   logic            mp0;
   logic            mp1;
   logic            go_hold;
   logic [VLEN-1:0] redirect_target;
   logic [PW-1:0]   wr_idx1;

   // Two free slots guaranteed whenever ready is high, so a dual push never
   // overflows. Based on the registered count only: a same-cycle pop does
   // not open the door.
   assign res_ready_o = (count_q <= CW'(DEPTH - 2));

   assign accept = (state_q == RUN) && res_ready_o && !flush_i;
   assign need0  = res_valid_i[0] && (res_cf_i[0] != NoCF);
   assign need1  = res_valid_i[1] && (res_cf_i[1] != NoCF);

   // A mispredicting port 0 puts port 1 on the wrong path.
   assign push0  = accept && need0;
   assign push1  = accept && need1 && !(need0 && res_mispredict_i[0]);

   assign mp0    = push0 && res_mispredict_i[0];
   assign mp1    = push1 && res_mispredict_i[1];
   assign go_hold = mp0 || mp1;
   assign redirect_target = mp0 ? res_target_i[0] : res_target_i[1];

   assign pop     = upd_valid_o && upd_ready_i;
   assign wr_idx1 = wr_ptr_q + PW'(push0);

   assign upd_valid_o  = (count_q != '0);
   assign upd_pc_o     = pc_mem[rd_ptr_q];
   assign upd_target_o = target_mem[rd_ptr_q];
   assign upd_taken_o  = taken_mem[rd_ptr_q];
   assign upd_cf_o     = cf_mem[rd_ptr_q];

   // Queue storage: contents are don't-care while count is zero.
   always_ff @(posedge clk_i) begin
      if (push0) begin
         pc_mem[wr_ptr_q]     <= res_pc_i[0];
         target_mem[wr_ptr_q] <= res_target_i[0];
         taken_mem[wr_ptr_q]  <= res_taken_i[0];
         cf_mem[wr_ptr_q]     <= res_cf_i[0];
      end
      if (push1) begin
         pc_mem[wr_idx1]     <= res_pc_i[1];
         target_mem[wr_idx1] <= res_target_i[1];
         taken_mem[wr_idx1]  <= res_taken_i[1];
         cf_mem[wr_idx1]     <= res_cf_i[1];
      end
   end

   // Pointers, occupancy, RUN/HOLD state and registered redirect.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q             <= RUN;
         wr_ptr_q            <= '0;
         rd_ptr_q            <= '0;
         count_q             <= '0;
         mispredict_o        <= 1'b0;
         mispredict_target_o <= '0;
         hold_o              <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_q + PW'(push0) + PW'(push1);
         rd_ptr_q <= rd_ptr_q + PW'(pop);
         count_q  <= count_q + CW'(push0) + CW'(push1) - CW'(pop);

         mispredict_o <= go_hold;
         if (go_hold) begin
            mispredict_target_o <= redirect_target;
         end

         case (state_q)
            RUN: begin
               // go_hold already excludes flush cycles.
               if (go_hold) begin
                  state_q <= HOLD;
                  hold_o  <= 1'b1;
               end
            end
            HOLD: begin
               if (flush_i) begin
                  state_q <= RUN;
                  hold_o  <= 1'b0;
               end
            end
            default: begin
               state_q <= RUN;
               hold_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bp_update_sched.sv
// Directed testbench for bp_update_sched (DEPTH=4, VLEN=64).
module tb_bp_update_sched;
   import bp_update_sched_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned VLEN  = 64;

   logic                 clk;
   logic                 rst_n;
   logic                 flush;
   logic [1:0]           res_valid;
   logic [1:0][VLEN-1:0] res_pc;
   logic [1:0][VLEN-1:0] res_target;
   logic [1:0]           res_taken;
   logic [1:0]           res_mispredict;
   cf_t  [1:0]           res_cf;
   logic                 res_ready;
   logic                 upd_valid;
   logic                 upd_ready;
   logic [VLEN-1:0]      upd_pc;
   logic [VLEN-1:0]      upd_target;
   logic                 upd_taken;
   cf_t                  upd_cf;
   logic                 mispredict;
   logic [VLEN-1:0]      mispredict_target;
   logic                 hold;

   int passed;
   int total;

   bp_update_sched #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
      .clk_i               (clk),
      .rst_ni              (rst_n),
      .flush_i             (flush),
      .res_valid_i         (res_valid),
      .res_pc_i            (res_pc),
      .res_target_i        (res_target),
      .res_taken_i         (res_taken),
      .res_mispredict_i    (res_mispredict),
      .res_cf_i            (res_cf),
      .res_ready_o         (res_ready),
      .upd_valid_o         (upd_valid),
      .upd_ready_i         (upd_ready),
      .upd_pc_o            (upd_pc),
      .upd_target_o        (upd_target),
      .upd_taken_o         (upd_taken),
      .upd_cf_o            (upd_cf),
      .mispredict_o        (mispredict),
      .mispredict_target_o (mispredict_target),
      .hold_o              (hold)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver tasks: inputs change 1 time unit after the rising edge,
   // outputs are sampled at the same point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush          = 1'b0;
      res_valid      = 2'b00;
      res_pc         = '0;
      res_target     = '0;
      res_taken      = 2'b00;
      res_mispredict = 2'b00;
      res_cf[0]      = NoCF;
      res_cf[1]      = NoCF;
   endtask

   task automatic drive_port(input int p, input logic [VLEN-1:0] pc,
                             input logic [VLEN-1:0] tgt, input logic tk,
                             input logic mp, input cf_t cf);
      res_valid[p]      = 1'b1;
      res_pc[p]         = pc;
      res_target[p]     = tgt;
      res_taken[p]      = tk;
      res_mispredict[p] = mp;
      res_cf[p]         = cf;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      upd_ready = 1'b0;
      idle_inputs();
      repeat (2) step();
      total++; if (upd_valid !== 1'b0) $display("FAIL reset_upd_valid got %b exp 0", upd_valid); else passed++;
      total++; if (hold !== 1'b0) $display("FAIL reset_hold got %b exp 0", hold); else passed++;
      total++; if (mispredict !== 1'b0) $display("FAIL reset_mispredict got %b exp 0", mispredict); else passed++;
      total++; if (mispredict_target !== '0) $display("FAIL reset_mp_target got %h exp 0", mispredict_target); else passed++;
      total++; if (res_ready !== 1'b1) $display("FAIL reset_res_ready got %b exp 1", res_ready); else passed++;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_dual_push();
      upd_ready = 1'b1;
      drive_port(0, 64'h100, 64'h180, 1'b1, 1'b0, Branch);
      drive_port(1, 64'h104, 64'h1c0, 1'b0, 1'b0, Branch);
      step();
      idle_inputs();
      total++; if (upd_valid !== 1'b1) $display("FAIL dual_valid0 got %b exp 1", upd_valid); else passed++;
      total++; if (upd_pc !== 64'h100) $display("FAIL dual_pc0 got %h exp 100", upd_pc); else passed++;
      total++; if (upd_target !== 64'h180) $display("FAIL dual_target0 got %h exp 180", upd_target); else passed++;
      total++; if (upd_taken !== 1'b1) $display("FAIL dual_taken0 got %b exp 1", upd_taken); else passed++;
      step();
      total++; if (upd_pc !== 64'h104) $display("FAIL dual_pc1 got %h exp 104", upd_pc); else passed++;
      total++; if (upd_taken !== 1'b0) $display("FAIL dual_taken1 got %b exp 0", upd_taken); else passed++;
      step();
      total++; if (upd_valid !== 1'b0) $display("FAIL dual_empty got %b exp 0", upd_valid); else passed++;
   endtask

   task automatic test_filter();
      upd_ready = 1'b0;
      drive_port(0, 64'h1f0, 64'h0, 1'b0, 1'b0, NoCF);
      drive_port(1, 64'h200, 64'h240, 1'b1, 1'b0, Jump);
      step();
      idle_inputs();
      total++; if (upd_valid !== 1'b1) $display("FAIL filter_valid got %b exp 1", upd_valid); else passed++;
      total++; if (upd_pc !== 64'h200) $display("FAIL filter_pc got %h exp 200", upd_pc); else passed++;
      total++; if (upd_cf !== Jump) $display("FAIL filter_cf got %0d exp %0d", upd_cf, Jump); else passed++;
      upd_ready = 1'b1;
      step();
      total++; if (upd_valid !== 1'b0) $display("FAIL filter_single got %b exp 0", upd_valid); else passed++;
   endtask

   task automatic test_full();
      upd_ready = 1'b0;
      drive_port(0, 64'h10, 64'h0, 1'b0, 1'b0, Branch);
      drive_port(1, 64'h14, 64'h0, 1'b0, 1'b0, Branch);
      step();
      total++; if (res_ready !== 1'b1) $display("FAIL full_ready_at2 got %b exp 1", res_ready); else passed++;
      drive_port(0, 64'h18, 64'h0, 1'b0, 1'b0, Branch);
      drive_port(1, 64'h1c, 64'h0, 1'b0, 1'b0, Branch);
      step();
      idle_inputs();
      total++; if (res_ready !== 1'b0) $display("FAIL full_ready_at4 got %b exp 0", res_ready); else passed++;
      drive_port(0, 64'h20, 64'h0, 1'b0, 1'b0, Branch);
      step();
      idle_inputs();
      total++; if (upd_pc !== 64'h10) $display("FAIL full_head got %h exp 10", upd_pc); else passed++;
      upd_ready = 1'b1;
      #1;
      total++; if (res_ready !== 1'b0) $display("FAIL full_ready_pop got %b exp 0", res_ready); else passed++;
      step();
      total++; if (upd_pc !== 64'h14) $display("FAIL full_pop1 got %h exp 14", upd_pc); else passed++;
      total++; if (res_ready !== 1'b0) $display("FAIL full_ready_at3 got %b exp 0", res_ready); else passed++;
      step();
      total++; if (upd_pc !== 64'h18) $display("FAIL full_pop2 got %h exp 18", upd_pc); else passed++;
      total++; if (res_ready !== 1'b1) $display("FAIL full_ready_back got %b exp 1", res_ready); else passed++;
      step();
      total++; if (upd_pc !== 64'h1c) $display("FAIL full_pop3 got %h exp 1c", upd_pc); else passed++;
      step();
      total++; if (upd_valid !== 1'b0) $display("FAIL full_drop5 got %b exp 0", upd_valid); else passed++;
   endtask

   task automatic test_mispredict();
      upd_ready = 1'b0;
      drive_port(0, 64'h280, 64'h300, 1'b1, 1'b1, Branch);
      drive_port(1, 64'h284, 64'h2c0, 1'b0, 1'b0, Branch);
      step();
      idle_inputs();
      total++; if (mispredict !== 1'b1) $display("FAIL mp_pulse got %b exp 1", mispredict); else passed++;
      total++; if (mispredict_target !== 64'h300) $display("FAIL mp_target got %h exp 300", mispredict_target); else passed++;
      total++; if (hold !== 1'b1) $display("FAIL mp_hold got %b exp 1", hold); else passed++;
      total++; if (upd_pc !== 64'h280) $display("FAIL mp_entry got %h exp 280", upd_pc); else passed++;
      drive_port(0, 64'h400, 64'h480, 1'b0, 1'b1, Branch);
      step();
      idle_inputs();
      total++; if (mispredict !== 1'b0) $display("FAIL mp_one_cycle got %b exp 0", mispredict); else passed++;
      total++; if (hold !== 1'b1) $display("FAIL mp_hold_kept got %b exp 1", hold); else passed++;
      flush = 1'b1;
      step();
      flush = 1'b0;
      total++; if (hold !== 1'b0) $display("FAIL mp_flush_run got %b exp 0", hold); else passed++;
      total++; if (upd_pc !== 64'h280) $display("FAIL mp_flush_keeps got %h exp 280", upd_pc); else passed++;
      upd_ready = 1'b1;
      step();
      total++; if (upd_valid !== 1'b0) $display("FAIL mp_one_entry got %b exp 0", upd_valid); else passed++;
   endtask

   task automatic test_flush_collision();
      upd_ready = 1'b1;
      flush = 1'b1;
      drive_port(1, 64'h4f0, 64'h500, 1'b1, 1'b1, Jump);
      step();
      idle_inputs();
      total++; if (upd_valid !== 1'b0) $display("FAIL fc_no_entry got %b exp 0", upd_valid); else passed++;
      total++; if (mispredict !== 1'b0) $display("FAIL fc_no_pulse got %b exp 0", mispredict); else passed++;
      total++; if (hold !== 1'b0) $display("FAIL fc_run got %b exp 0", hold); else passed++;
   endtask

   task automatic test_async_reset();
      upd_ready = 1'b0;
      drive_port(0, 64'h600, 64'h0, 1'b0, 1'b0, Branch);
      drive_port(1, 64'h604, 64'h0, 1'b0, 1'b0, Branch);
      step();
      idle_inputs();
      drive_port(0, 64'h608, 64'h700, 1'b1, 1'b1, Branch);
      step();
      idle_inputs();
      total++; if (hold !== 1'b1) $display("FAIL ar_pre_hold got %b exp 1", hold); else passed++;
      total++; if (upd_pc !== 64'h600) $display("FAIL ar_pre_head got %h exp 600", upd_pc); else passed++;
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (upd_valid !== 1'b0) $display("FAIL ar_upd_valid got %b exp 0", upd_valid); else passed++;
      total++; if (hold !== 1'b0) $display("FAIL ar_hold got %b exp 0", hold); else passed++;
      total++; if (mispredict !== 1'b0) $display("FAIL ar_pulse got %b exp 0", mispredict); else passed++;
      total++; if (res_ready !== 1'b1) $display("FAIL ar_ready got %b exp 1", res_ready); else passed++;
      step();
      rst_n = 1'b1;
      step();
      total++; if (upd_valid !== 1'b0) $display("FAIL ar_entries_lost got %b exp 0", upd_valid); else passed++;
   endtask

   // Test sequence and final report
   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_dual_push();
      test_filter();
      test_full();
      test_mispredict();
      test_flush_collision();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
